// File: rtl/lsu_ctrl.sv
// Load/store sequencer: splits word-crossing accesses into two aligned bus
// transactions, rotates store data into byte lanes and aligns/extends load data.
module lsu_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_length,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_we,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_lo, r_rdata;
  logic        r_we, r_signed, r_err;
  logic [1:0]  r_len;

  logic        w_accept, w_split, w_done;
  logic [1:0]  w_shift;
  logic [2:0]  w_bytes;
  logic [3:0]  w_end, w_ones;
  logic [7:0]  w_mask;
  logic [4:0]  w_bshift;
  logic [31:0] w_base, w_hi, w_lo, w_t, w_ldata, w_rot;

  assign w_accept = i_req_valid && (r_state == StIdle);
  assign w_shift  = r_addr[1:0];
  assign w_bshift = {w_shift, 3'b000};
  assign w_base   = {r_addr[31:2], 2'b00};

  always_comb begin
    w_bytes = 3'd4;
    w_ones  = 4'b1111;
    case (r_len)
      2'd0:    begin w_bytes = 3'd1; w_ones = 4'b0001; end
      2'd1:    begin w_bytes = 3'd2; w_ones = 4'b0011; end
      default: begin w_bytes = 3'd4; w_ones = 4'b1111; end
    endcase
  end

  assign w_end   = {2'b00, w_shift} + {1'b0, w_bytes};
  assign w_split = w_end > 4'd4;
  assign w_mask  = {4'b0000, w_ones} << w_shift;
  // Rotate left by 8*shift: take the upper half of the doubled word shifted right.
  assign w_rot   = 32'({r_wdata, r_wdata} >> (6'd32 - {1'b0, w_bshift}));

  // In ACC0 the returned word is lo with hi = 0; in ACC1 it is hi.
  assign w_lo = (r_state == StAcc1) ? r_lo : i_bus_rdata;
  assign w_hi = (r_state == StAcc1) ? i_bus_rdata : 32'h0;
  assign w_t  = 32'({w_hi, w_lo} >> w_bshift);

  always_comb begin
    w_ldata = w_t;
    case (r_len)
      2'd0:    w_ldata = {{24{r_signed & w_t[7]}}, w_t[7:0]};
      2'd1:    w_ldata = {{16{r_signed & w_t[15]}}, w_t[15:0]};
      default: w_ldata = w_t;
    endcase
  end

  assign w_done = i_bus_ack && ((r_state == StAcc0 && !w_split) || (r_state == StAcc1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_next = (i_req_length == 2'd3) ? StResp : StAcc0;
      StAcc0: if (i_bus_ack) w_state_next = w_split ? StAcc1 : StResp;
      StAcc1: if (i_bus_ack) w_state_next = StResp;
      StResp: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_we     <= 1'b0;
      r_len    <= 2'd0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_lo     <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_we     <= i_req_we;
        r_len    <= i_req_length;
        r_signed <= i_req_signed;
        r_err    <= (i_req_length == 2'd3);
        r_rdata  <= 32'h0;
      end
      if (r_state == StAcc0 && i_bus_ack) r_lo <= i_bus_rdata;
      if (w_done) r_rdata <= r_we ? 32'h0 : w_ldata;
    end
  end

  always_comb begin
    o_req_ready  = (r_state == StIdle);
    o_resp_valid = (r_state == StResp);
    o_resp_err   = (r_state == StResp) && r_err;
    o_resp_rdata = r_rdata;
    o_bus_req    = 1'b0;
    o_bus_addr   = 32'h0;
    o_bus_we     = 4'b0000;
    o_bus_wdata  = 32'h0;
    case (r_state)
      StAcc0: begin
        o_bus_req   = 1'b1;
        o_bus_addr  = w_base;
        o_bus_we    = r_we ? w_mask[3:0] : 4'b0000;
        o_bus_wdata = r_we ? w_rot : 32'h0;
      end
      StAcc1: begin
        o_bus_req   = 1'b1;
        o_bus_addr  = w_base + 32'd4;
        o_bus_we    = r_we ? w_mask[7:4] : 4'b0000;
        o_bus_wdata = r_we ? w_rot : 32'h0;
      end
      default: ;
    endcase
  end

endmodule
